actag_pasid_table: RTL

- Receive-side counterpart of the acTag assignment path.
- Consumes the AFU→TLX command stream and records every assign_actag (opcode 0x50) as an acTag→PASID binding.
- Resolves the PASID of each following command from its acTag and forwards the command with that PASID.
- Flags commands whose acTag is unassigned or out of range; used in the TLX-side command model and as an in-line protocol checker.

---
 rtl/actag_pkg.sv | 21 ++
 rtl/actag_table_mem.sv | 37 +++
 rtl/actag_pasid_table.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/actag_pkg.sv
// Shared definitions for the acTag -> PASID table: opcodes, table entry
// layout and error-bit encoding.
package actag_pkg;

    localparam logic [7:0] OP_NOP          = 8'h00;
    localparam logic [7:0] OP_RD_WNITC     = 8'h10;
    localparam logic [7:0] OP_DMA_W        = 8'h20;
    localparam logic [7:0] ASSIGN_ACTAG    = 8'h50;

    localparam int         ERR_RANGE_BIT   = 0;
    localparam int         ERR_UNASGN_BIT  = 1;
    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_RANGE       = 2'b01;
    localparam logic [1:0] ERR_UNASSIGNED  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [19:0] pasid;
    } actag_entry_t;

endpackage

// File: rtl/actag_table_mem.sv
// acTag binding storage: one register per entry, single write port,
// combinational read port, synchronous flush of all valid bits.
// A write in the flush cycle lands after the clear, so its entry stays valid.
module actag_table_mem
    import actag_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [19:0]      wr_pasid,
    input  logic [IDX_W-1:0] rd_idx,
    output actag_entry_t     rd_entry
);

    actag_entry_t mem [ENTRIES];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        // Per-entry register: write wins over flush, flush only drops valid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[i] <= '0;
            end else if (wr_en && wr_idx == IDX_W'(i)) begin
                mem[i] <= '{valid: 1'b1, pasid: wr_pasid};
            end else if (flush) begin
                mem[i].valid <= 1'b0;
            end
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/actag_pasid_table.sv
// Receive-side acTag table: records assign_actag bindings from the command
// stream and forwards every other command with its resolved PASID through a
// single registered output stage, flagging range / unassigned acTags.
// Optional feature macro: ACTAG_TABLE_STATS_EN adds assign/hit counters.
module actag_pasid_table
    import actag_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [11:0]          cfg_actag_base,
    input  logic [11:0]          cfg_actag_len,
    input  logic                 table_flush,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_opcode,
    input  logic [11:0]          cmd_actag,
    input  logic [19:0]          cmd_pasid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_opcode,
    output logic [11:0]          out_actag,
    output logic [19:0]          out_pasid,
    output logic [1:0]           out_err,
    output logic [1:0]           err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef ACTAG_TABLE_STATS_EN
    ,
    output logic [31:0]          stat_assign_cnt,
    output logic [31:0]          stat_hit_cnt
`endif
);

    localparam int          IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [11:0] DEPTH   = 12'(ENTRIES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [11:0]  idx;
    logic         in_range;
    logic         accept;
    logic         is_assign;
    logic         wr_en;
    logic [1:0]   lk_err;
    logic         err_ev;
    logic [1:0]   err_bits;
    actag_entry_t rd_entry;

    // acTags below base wrap to a huge index and fall out of range naturally
    assign idx       = cmd_actag - cfg_actag_base;
    assign in_range  = (idx < cfg_actag_len) && (idx < DEPTH);
    assign cmd_ready = ~out_valid | out_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign is_assign = (cmd_opcode == ASSIGN_ACTAG);
    assign wr_en     = accept & is_assign & in_range;

    actag_table_mem #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (table_flush),
        .wr_en    (wr_en),
        .wr_idx   (idx[IDX_W-1:0]),
        .wr_pasid (cmd_pasid),
        .rd_idx   (idx[IDX_W-1:0]),
        .rd_entry (rd_entry)
    );

    // Lookup error: range error masks the unassigned check
    always_comb begin
        lk_err = ERR_NONE;
        if (!in_range)            lk_err = ERR_RANGE;
        else if (!rd_entry.valid) lk_err = ERR_UNASSIGNED;
    end

    // Error event for this accepted command (dropped assign or bad lookup)
    always_comb begin
        err_ev   = 1'b0;
        err_bits = ERR_NONE;
        if (accept) begin
            if (is_assign) begin
                err_ev   = ~in_range;
                err_bits = in_range ? ERR_NONE : ERR_RANGE;
            end else begin
                err_ev   = |lk_err;
                err_bits = lk_err;
            end
        end
    end

    // Output stage: load on accepted non-assign, drop when downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_actag  <= '0;
            out_pasid  <= '0;
            out_err    <= '0;
        end else if (accept && !is_assign) begin
            out_valid  <= 1'b1;
            out_opcode <= cmd_opcode;
            out_actag  <= cmd_actag;
            out_pasid  <= (lk_err == ERR_NONE) ? rd_entry.pasid : 20'h0;
            out_err    <= lk_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Sticky errors clear on flush; an error in the flush cycle still lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sticky <= '0;
        else        err_sticky <= (table_flush ? 2'b00 : err_sticky) | err_bits;
    end

    // Saturating error count, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err_cnt <= '0;
        else if (err_ev && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
    end

`ifdef ACTAG_TABLE_STATS_EN
    // Wrapping usage counters: in-range assigns and clean lookups
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_assign_cnt <= '0;
            stat_hit_cnt    <= '0;
        end else begin
            if (wr_en)
                stat_assign_cnt <= stat_assign_cnt + 32'd1;
            if (accept && !is_assign && lk_err == ERR_NONE)
                stat_hit_cnt    <= stat_hit_cnt + 32'd1;
        end
    end
`endif

endmodule
